// File: rtl/mc_defs_pkg.sv
// ============================================================================
// mc_defs : shared encodings for the multicycle MIPS control FSM
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package mc_defs;

  typedef enum logic [3:0] {
    ST_IF   = 4'd0,
    ST_ID   = 4'd1,
    ST_MADR = 4'd2,
    ST_MRD  = 4'd3,
    ST_LWB  = 4'd4,
    ST_MWR  = 4'd5,
    ST_REXE = 4'd6,
    ST_RWB  = 4'd7,
    ST_BR   = 4'd8,
    ST_J    = 4'd9,
    ST_IEXE = 4'd10,
    ST_IWB  = 4'd11,
    ST_LUI  = 4'd12,
    ST_JAL  = 4'd13,
    ST_JR   = 4'd14
  } state_t;

  localparam logic [5:0] c_OP_R    = 6'b000000;
  localparam logic [5:0] c_OP_LW   = 6'b100011;
  localparam logic [5:0] c_OP_SW   = 6'b101011;
  localparam logic [5:0] c_OP_BEQ  = 6'b000100;
  localparam logic [5:0] c_OP_BNE  = 6'b000101;
  localparam logic [5:0] c_OP_J    = 6'b000010;
  localparam logic [5:0] c_OP_JAL  = 6'b000011;
  localparam logic [5:0] c_OP_ADDI = 6'b001000;
  localparam logic [5:0] c_OP_ANDI = 6'b001100;
  localparam logic [5:0] c_OP_ORI  = 6'b001101;
  localparam logic [5:0] c_OP_SLTI = 6'b001010;
  localparam logic [5:0] c_OP_LUI  = 6'b001111;

  localparam logic [5:0] c_F_ADD = 6'b100000;
  localparam logic [5:0] c_F_SUB = 6'b100010;
  localparam logic [5:0] c_F_AND = 6'b100100;
  localparam logic [5:0] c_F_OR  = 6'b100101;
  localparam logic [5:0] c_F_SLT = 6'b101010;
  localparam logic [5:0] c_F_NOR = 6'b100111;
  localparam logic [5:0] c_F_SRL = 6'b000010;
  localparam logic [5:0] c_F_XOR = 6'b100110;
  localparam logic [5:0] c_F_JR  = 6'b001000;

  localparam logic [2:0] c_ALU_AND = 3'b000;
  localparam logic [2:0] c_ALU_OR  = 3'b001;
  localparam logic [2:0] c_ALU_ADD = 3'b010;
  localparam logic [2:0] c_ALU_XOR = 3'b011;
  localparam logic [2:0] c_ALU_NOR = 3'b100;
  localparam logic [2:0] c_ALU_SRL = 3'b101;
  localparam logic [2:0] c_ALU_SUB = 3'b110;
  localparam logic [2:0] c_ALU_SLT = 3'b111;

  localparam logic [1:0] c_RDST_RT = 2'b00;
  localparam logic [1:0] c_RDST_RD = 2'b01;
  localparam logic [1:0] c_RDST_RA = 2'b10;

  localparam logic [1:0] c_M2R_ALU = 2'b00;
  localparam logic [1:0] c_M2R_MDR = 2'b01;
  localparam logic [1:0] c_M2R_LUI = 2'b10;
  localparam logic [1:0] c_M2R_PC  = 2'b11;

  localparam logic [1:0] c_PCS_ALU    = 2'b00;
  localparam logic [1:0] c_PCS_ALUOUT = 2'b01;
  localparam logic [1:0] c_PCS_JUMP   = 2'b10;
  localparam logic [1:0] c_PCS_RS     = 2'b11;

  localparam logic [1:0] c_SRCB_RT  = 2'b00;
  localparam logic [1:0] c_SRCB_4   = 2'b01;
  localparam logic [1:0] c_SRCB_IMM = 2'b10;
  localparam logic [1:0] c_SRCB_BR  = 2'b11;

endpackage

`default_nettype wire

// File: rtl/alu_fun_dec.sv
// ============================================================================
// alu_fun_dec : R-type funct field to ALU_Control decoder with valid flag
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module alu_fun_dec
  import mc_defs::*;
(
  input  logic [5:0] i_fun,
  output logic [2:0] o_alu_ctrl,
  output logic       o_valid
);

  always_comb begin
    o_alu_ctrl = c_ALU_AND;
    o_valid    = 1'b1;
    case (i_fun)
      c_F_ADD: o_alu_ctrl = c_ALU_ADD;
      c_F_SUB: o_alu_ctrl = c_ALU_SUB;
      c_F_AND: o_alu_ctrl = c_ALU_AND;
      c_F_OR:  o_alu_ctrl = c_ALU_OR;
      c_F_SLT: o_alu_ctrl = c_ALU_SLT;
      c_F_NOR: o_alu_ctrl = c_ALU_NOR;
      c_F_SRL: o_alu_ctrl = c_ALU_SRL;
      c_F_XOR: o_alu_ctrl = c_ALU_XOR;
      default: o_valid = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mc_ctrl.sv
// ============================================================================
// mc_ctrl : Moore control FSM sequencing the multicycle MIPS datapath
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module mc_ctrl
  import mc_defs::*;
#(
  parameter int ST_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [5:0]      OPcode,
  input  logic [5:0]      Fun,
  input  logic            zero,
  input  logic            MIO_ready,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            IorD,
  output logic            IRWrite,
  output logic            PCWrite,
  output logic [1:0]      PCSource,
  output logic            ALUSrcA,
  output logic [1:0]      ALUSrcB,
  output logic            ImmZext,
  output logic [2:0]      ALU_Control,
  output logic [1:0]      RegDst,
  output logic [1:0]      MemtoReg,
  output logic            RegWrite,
  output logic [ST_W-1:0] state_out
);

  state_t     r_state;
  state_t     w_next;
  logic       w_mem_read, w_mem_write, w_iord, w_irwrite, w_pcwrite;
  logic       w_alusrca, w_immzext, w_regwrite;
  logic [1:0] w_pcsource, w_alusrcb, w_regdst, w_memtoreg;
  logic [2:0] w_alu;
  logic [2:0] w_fun_alu;
  logic       w_fun_valid;
  logic [2:0] w_imm_alu;
  logic       w_imm_zext;

  alu_fun_dec u_fun_dec (
    .i_fun      (Fun),
    .o_alu_ctrl (w_fun_alu),
    .o_valid    (w_fun_valid)
  );

  // ALU/extension setting for I-type arithmetic, shared by IEXE and IWB
  always_comb begin
    w_imm_alu  = c_ALU_ADD;
    w_imm_zext = 1'b0;
    case (OPcode)
      c_OP_ANDI: begin w_imm_alu = c_ALU_AND; w_imm_zext = 1'b1; end
      c_OP_ORI:  begin w_imm_alu = c_ALU_OR;  w_imm_zext = 1'b1; end
      c_OP_SLTI: w_imm_alu = c_ALU_SLT;
      default:   ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IF;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = ST_IF;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_iord      = 1'b0;
    w_irwrite   = 1'b0;
    w_pcwrite   = 1'b0;
    w_pcsource  = c_PCS_ALU;
    w_alusrca   = 1'b0;
    w_alusrcb   = c_SRCB_RT;
    w_immzext   = 1'b0;
    w_alu       = c_ALU_AND;
    w_regdst    = c_RDST_RT;
    w_memtoreg  = c_M2R_ALU;
    w_regwrite  = 1'b0;
    case (r_state)
      ST_IF: begin
        w_mem_read = 1'b1;
        w_alusrcb  = c_SRCB_4;
        w_alu      = c_ALU_ADD;
        w_irwrite  = MIO_ready;
        w_pcwrite  = MIO_ready;
        w_next     = MIO_ready ? ST_ID : ST_IF;
      end
      ST_ID: begin
        w_alusrcb = c_SRCB_BR;
        w_alu     = c_ALU_ADD;
        case (OPcode)
          c_OP_LW, c_OP_SW:                          w_next = ST_MADR;
          c_OP_R:                                    w_next = ST_REXE;
          c_OP_BEQ, c_OP_BNE:                        w_next = ST_BR;
          c_OP_J:                                    w_next = ST_J;
          c_OP_JAL:                                  w_next = ST_JAL;
          c_OP_ADDI, c_OP_ANDI, c_OP_ORI, c_OP_SLTI: w_next = ST_IEXE;
          c_OP_LUI:                                  w_next = ST_LUI;
          default:                                   w_next = ST_IF;
        endcase
      end
      ST_MADR: begin
        w_alusrca = 1'b1;
        w_alusrcb = c_SRCB_IMM;
        w_alu     = c_ALU_ADD;
        w_next    = (OPcode == c_OP_LW) ? ST_MRD : ST_MWR;
      end
      ST_MRD: begin
        w_mem_read = 1'b1;
        w_iord     = 1'b1;
        w_next     = MIO_ready ? ST_LWB : ST_MRD;
      end
      ST_LWB: begin
        w_regdst   = c_RDST_RT;
        w_memtoreg = c_M2R_MDR;
        w_regwrite = 1'b1;
      end
      ST_MWR: begin
        w_mem_write = 1'b1;
        w_iord      = 1'b1;
        w_next      = MIO_ready ? ST_IF : ST_MWR;
      end
      ST_REXE: begin
        w_alusrca = 1'b1;
        w_alusrcb = c_SRCB_RT;
        w_alu     = w_fun_alu;
        if (Fun == c_F_JR)    w_next = ST_JR;
        else if (w_fun_valid) w_next = ST_RWB;
        else                  w_next = ST_IF;
      end
      ST_RWB: begin
        w_regdst   = c_RDST_RD;
        w_memtoreg = c_M2R_ALU;
        w_regwrite = 1'b1;
        w_alu      = w_fun_alu;
      end
      ST_BR: begin
        w_alusrca  = 1'b1;
        w_alusrcb  = c_SRCB_RT;
        w_alu      = c_ALU_SUB;
        w_pcsource = c_PCS_ALUOUT;
        w_pcwrite  = (OPcode == c_OP_BEQ) ? zero : ~zero;
      end
      ST_J: begin
        w_pcsource = c_PCS_JUMP;
        w_pcwrite  = 1'b1;
      end
      ST_IEXE, ST_IWB: begin
        w_alusrca = 1'b1;
        w_alusrcb = c_SRCB_IMM;
        w_alu     = w_imm_alu;
        w_immzext = w_imm_zext;
        if (r_state == ST_IEXE) begin
          w_next = ST_IWB;
        end else begin
          w_regdst   = c_RDST_RT;
          w_memtoreg = c_M2R_ALU;
          w_regwrite = 1'b1;
        end
      end
      ST_LUI: begin
        w_regdst   = c_RDST_RT;
        w_memtoreg = c_M2R_LUI;
        w_regwrite = 1'b1;
      end
      // PC already holds PC+4 here, so r31 receives the return address
      ST_JAL: begin
        w_regdst   = c_RDST_RA;
        w_memtoreg = c_M2R_PC;
        w_regwrite = 1'b1;
        w_pcsource = c_PCS_JUMP;
        w_pcwrite  = 1'b1;
      end
      ST_JR: begin
        w_pcsource = c_PCS_RS;
        w_pcwrite  = 1'b1;
      end
      default: w_next = ST_IF;
    endcase
  end

  // Reset masks every control so an aborted instruction issues no writes
  assign MemRead     = w_mem_read  & ~rst;
  assign MemWrite    = w_mem_write & ~rst;
  assign IorD        = w_iord      & ~rst;
  assign IRWrite     = w_irwrite   & ~rst;
  assign PCWrite     = w_pcwrite   & ~rst;
  assign PCSource    = rst ? 2'b00 : w_pcsource;
  assign ALUSrcA     = w_alusrca   & ~rst;
  assign ALUSrcB     = rst ? 2'b00 : w_alusrcb;
  assign ImmZext     = w_immzext   & ~rst;
  assign ALU_Control = rst ? 3'b000 : w_alu;
  assign RegDst      = rst ? 2'b00 : w_regdst;
  assign MemtoReg    = rst ? 2'b00 : w_memtoreg;
  assign RegWrite    = w_regwrite  & ~rst;
  assign state_out   = ST_W'(r_state);

endmodule

`default_nettype wire

// File: tb/tb_mc_ctrl.sv
// ============================================================================
// tb_mc_ctrl : directed, model-checked bench for the mc_ctrl control FSM
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst, zero, MIO_ready;
  logic [5:0] OPcode, Fun;
  logic       MemRead, MemWrite, IorD, IRWrite, PCWrite, ALUSrcA, ImmZext, RegWrite;
  logic [1:0] PCSource, ALUSrcB, RegDst, MemtoReg;
  logic [2:0] ALU_Control;
  logic [3:0] state_out;

  always #5 clk = ~clk;

  mc_ctrl #(.ST_W(4)) dut (
    .clk(clk), .rst(rst), .OPcode(OPcode), .Fun(Fun), .zero(zero),
    .MIO_ready(MIO_ready), .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSource(PCSource), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ImmZext(ImmZext), .ALU_Control(ALU_Control),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .state_out(state_out)
  );

  typedef struct packed {
    logic       mem_read, mem_write, iord, ir_write, pc_write;
    logic [1:0] pc_source;
    logic       srca;
    logic [1:0] srcb;
    logic       zext;
    logic [2:0] alu;
    logic [1:0] reg_dst, mem_to_reg;
    logic       reg_write;
    logic [3:0] st;
  } ctl_t;

  ctl_t w_dut, exp_c, smp;
  logic exp_valid = 1'b0;
  int   n_pass = 0, n_total = 0;

  assign w_dut = {MemRead, MemWrite, IorD, IRWrite, PCWrite, PCSource, ALUSrcA,
                  ALUSrcB, ImmZext, ALU_Control, RegDst, MemtoReg, RegWrite, state_out};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, expv);
  endtask

  // {known, alu code} for an R-type funct; jr and unknown functs report 0
  function automatic logic [3:0] fun_alu(input logic [5:0] f);
    case (f)
      6'b100000: return 4'b1010;
      6'b100010: return 4'b1110;
      6'b100100: return 4'b1000;
      6'b100101: return 4'b1001;
      6'b101010: return 4'b1111;
      6'b100111: return 4'b1100;
      6'b000010: return 4'b1101;
      6'b100110: return 4'b1011;
      default:   return 4'b0000;
    endcase
  endfunction

  function automatic ctl_t model(input int st, input logic [5:0] op, input logic [5:0] fun,
                                 input logic z, input logic mio, input logic r);
    ctl_t c;
    c = '0;
    c.st = 4'(st);
    if (r) return c;
    case (st)
      0:  begin c.mem_read = 1; c.srcb = 2'b01; c.alu = 3'b010; c.ir_write = mio; c.pc_write = mio; end
      1:  begin c.srcb = 2'b11; c.alu = 3'b010; end
      2:  begin c.srca = 1; c.srcb = 2'b10; c.alu = 3'b010; end
      3:  begin c.mem_read = 1; c.iord = 1; end
      4:  begin c.mem_to_reg = 2'b01; c.reg_write = 1; end
      5:  begin c.mem_write = 1; c.iord = 1; end
      6:  begin c.srca = 1; c.alu = fun_alu(fun)[2:0]; end
      7:  begin c.reg_dst = 2'b01; c.reg_write = 1; c.alu = fun_alu(fun)[2:0]; end
      8:  begin c.srca = 1; c.alu = 3'b110; c.pc_source = 2'b01;
                c.pc_write = (op == 6'b000100) ? z : ~z; end
      9:  begin c.pc_source = 2'b10; c.pc_write = 1; end
      10, 11: begin
        c.srca = 1; c.srcb = 2'b10;
        c.alu  = (op == 6'b001100) ? 3'b000 : (op == 6'b001101) ? 3'b001 :
                 (op == 6'b001010) ? 3'b111 : 3'b010;
        c.zext = (op == 6'b001100) || (op == 6'b001101);
        c.reg_write = (st == 11);
      end
      12: begin c.mem_to_reg = 2'b10; c.reg_write = 1; end
      13: begin c.reg_dst = 2'b10; c.mem_to_reg = 2'b11; c.reg_write = 1;
                c.pc_source = 2'b10; c.pc_write = 1; end
      14: begin c.pc_source = 2'b11; c.pc_write = 1; end
      default: ;
    endcase
    return c;
  endfunction

  initial forever begin
    @(negedge clk);
    if (exp_valid) begin
      smp = w_dut;
      check($sformatf("cycle st=%0d op=%b", exp_c.st, OPcode), 64'(smp), 64'(exp_c));
    end
  end

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  task automatic step(input int st, input logic mio, input logic r);
    rst       = r;
    MIO_ready = mio;
    exp_c     = model(st, OPcode, Fun, zero, mio, r);
    exp_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [5:0] op, input logic [5:0] fun, input logic z,
                     input int ifw, input int memw);
    OPcode = op; Fun = fun; zero = z;
    for (int i = 0; i < ifw; i++) step(0, 1'b0, 1'b0);
    step(0, 1'b1, 1'b0);
    step(1, rb(), 1'b0);
    case (op)
      6'b000000: begin
        step(6, rb(), 1'b0);
        if (fun == 6'b001000)  step(14, rb(), 1'b0);
        else if (fun_alu(fun)[3]) step(7, rb(), 1'b0);
      end
      6'b100011: begin
        step(2, rb(), 1'b0);
        for (int i = 0; i < memw; i++) step(3, 1'b0, 1'b0);
        step(3, 1'b1, 1'b0);
        step(4, rb(), 1'b0);
      end
      6'b101011: begin
        step(2, rb(), 1'b0);
        for (int i = 0; i < memw; i++) step(5, 1'b0, 1'b0);
        step(5, 1'b1, 1'b0);
      end
      6'b000100, 6'b000101: step(8, rb(), 1'b0);
      6'b000010: step(9, rb(), 1'b0);
      6'b000011: step(13, rb(), 1'b0);
      6'b001000, 6'b001100, 6'b001101, 6'b001010: begin
        step(10, rb(), 1'b0);
        step(11, rb(), 1'b0);
      end
      6'b001111: step(12, rb(), 1'b0);
      default: ;
    endcase
  endtask

  logic [5:0] t_op  [14] = '{6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000,
                             6'b000000, 6'b000000, 6'b001000, 6'b001100, 6'b001101,
                             6'b001010, 6'b001111, 6'b000010, 6'b101011};
  logic [5:0] t_fun [14] = '{6'b100010, 6'b101010, 6'b000010, 6'b100110, 6'b100111,
                             6'b111111, 6'b001000, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0};

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; MIO_ready = 1'b0; OPcode = 6'b0; Fun = 6'b0; zero = 1'b0;
    @(posedge clk);
    #1;
    step(0, 1'b1, 1'b1);
    check("reset_all_zero", 64'(smp), 64'd0);

    OPcode = 6'b000000; Fun = 6'b100000;
    step(0, 1'b1, 1'b0);
    check("if_fetch", {smp.st, smp.mem_read, smp.ir_write, smp.pc_write}, {4'd0, 3'b111});
    step(1, 1'b1, 1'b0);
    step(6, 1'b1, 1'b0);
    step(7, 1'b1, 1'b0);
    check("add_rwb", {smp.st, smp.reg_write, smp.reg_dst, smp.alu}, {4'd7, 6'b1_01_010});

    run(6'b100011, 6'b0, 1'b0, 0, 3);
    check("lw_wb", {smp.st, smp.reg_write, smp.mem_to_reg}, {4'd4, 3'b1_01});
    run(6'b000100, 6'b0, 1'b1, 0, 0);
    check("beq_taken", {smp.st, smp.pc_write, smp.pc_source}, {4'd8, 3'b1_01});
    run(6'b000101, 6'b0, 1'b1, 0, 0);
    check("bne_not_taken", {smp.st, smp.pc_write, smp.pc_source}, {4'd8, 3'b0_01});
    run(6'b000011, 6'b0, 1'b0, 0, 0);
    check("jal", {smp.st, smp.reg_dst, smp.mem_to_reg, smp.reg_write, smp.pc_source, smp.pc_write},
          {4'd13, 2'b10, 2'b11, 1'b1, 2'b10, 1'b1});
    run(6'b111111, 6'b0, 1'b0, 0, 0);
    check("illegal_id", {smp.st, smp.reg_write, smp.mem_write}, {4'd1, 2'b00});

    for (int i = 0; i < 14; i++) run(t_op[i], t_fun[i], 1'b0, i % 3, 2);
    run(6'b000100, 6'b0, 1'b0, 1, 0);
    run(6'b000101, 6'b0, 1'b0, 0, 0);

    OPcode = 6'b101011; Fun = 6'b0;
    step(0, 1'b1, 1'b0);
    step(1, 1'b1, 1'b0);
    step(2, 1'b1, 1'b0);
    step(5, 1'b0, 1'b1);
    check("sw_reset_abort", {smp.st, smp.mem_write, smp.reg_write}, {4'd5, 2'b00});
    step(0, 1'b1, 1'b0);
    exp_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
